// File: rtl/floor_ctrl.sv
// floor_ctrl: single-car elevator controller with latched floor calls and a status RGB LED
// Ports: clk; rst (async, active-high); req[FLOORS] level floor calls; cur_floor current floor;
//   req_pend latched unserved calls; moving / dir_up / door_open car status;
//   LED4_R/G/B registered status LED (R = door, G = idle, B = moving).
// Define FLOOR_CTRL_BLINK_EN to blink B while moving and R in the last quarter of the door cycle.
module floor_ctrl #(
    parameter int FLOORS     = 4,
    parameter int TRAVEL_CYC = 50000000,
    parameter int DOOR_CYC   = 100000000,
    localparam int FW        = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] req,
    output logic [FW-1:0]     cur_floor,
    output logic [FLOORS-1:0] req_pend,
    output logic              moving,
    output logic              dir_up,
    output logic              door_open,
    output logic              LED4_R,
    output logic              LED4_G,
    output logic              LED4_B
);
    localparam int TMAX = TRAVEL_CYC > DOOR_CYC ? TRAVEL_CYC : DOOR_CYC;
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_END = TW'(TRAVEL_CYC - 1);
    localparam logic [TW-1:0] D_END = TW'(DOOR_CYC - 1);
    localparam logic [FW-1:0] TOP = FW'(FLOORS - 1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

    state_t            state, state_n;
    logic [FW-1:0]     floor_n;
    logic [TW-1:0]     timer, timer_n;
    logic [FLOORS-1:0] clr;
    logic              dir_n, move_n;
    logic              above, below, far_above, far_below;

    // far_* look past the floor the car is about to reach
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        far_above = 1'b0;
        far_below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            above |= req_pend[i] && i > int'(cur_floor);
            below |= req_pend[i] && i < int'(cur_floor);
            far_above |= req_pend[i] && i > int'(cur_floor) + 1;
            far_below |= req_pend[i] && i < int'(cur_floor) - 1;
        end
    end

    always_comb begin
        state_n = state;
        floor_n = cur_floor;
        timer_n = timer + 1'b1;
        dir_n = dir_up;
        clr = '0;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (req_pend[cur_floor]) begin
                    state_n = DOOR;
                    clr[cur_floor] = 1'b1;
                end else if (|req_pend) begin
                    state_n = (dir_up && above) || !below ? MOVE_UP : MOVE_DOWN;
                    dir_n = state_n == MOVE_UP;
                end
            end
            MOVE_UP: begin
                if (cur_floor == TOP) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else if (timer == T_END) begin
                    floor_n = cur_floor + 1'b1;
                    timer_n = '0;
                    if (req_pend[floor_n]) begin
                        state_n = DOOR;
                        clr[floor_n] = 1'b1;
                    end else if (!far_above) begin
                        state_n = IDLE;
                    end
                end
            end
            MOVE_DOWN: begin
                if (cur_floor == '0) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else if (timer == T_END) begin
                    floor_n = cur_floor - 1'b1;
                    timer_n = '0;
                    if (req_pend[floor_n]) begin
                        state_n = DOOR;
                        clr[floor_n] = 1'b1;
                    end else if (!far_below) begin
                        state_n = IDLE;
                    end
                end
            end
            DOOR: begin
                // a call at the open floor is absorbed and holds the door open
                clr[cur_floor] = 1'b1;
                if (req[cur_floor]) begin
                    timer_n = '0;
                end else if (timer == D_END) begin
                    state_n = IDLE;
                    timer_n = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cur_floor <= '0;
            req_pend <= '0;
            timer <= '0;
            dir_up <= 1'b1;
        end else begin
            state <= state_n;
            cur_floor <= floor_n;
            req_pend <= (req_pend | req) & ~clr;
            timer <= timer_n;
            dir_up <= dir_n;
        end
    end

    assign moving = state == MOVE_UP || state == MOVE_DOWN;
    assign door_open = state == DOOR;
    assign move_n = state_n == MOVE_UP || state_n == MOVE_DOWN;

`ifdef FLOOR_CTRL_BLINK_EN
    localparam int TQ = TRAVEL_CYC / 4 > 0 ? TRAVEL_CYC / 4 : 1;
    localparam int DQ = DOOR_CYC / 4 > 0 ? DOOR_CYC / 4 : 1;
    localparam logic [TW-1:0] D_LAST = TW'(DOOR_CYC - DQ);

    logic [TW-1:0] blink;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            LED4_R <= 1'b0;
            LED4_G <= 1'b1;
            LED4_B <= 1'b0;
            blink <= '0;
        end else begin
            LED4_G <= state_n == IDLE;
            if (move_n) begin
                LED4_R <= 1'b0;
                if (!moving) begin
                    LED4_B <= 1'b1;
                    blink <= '0;
                end else if (blink == TW'(TQ - 1)) begin
                    LED4_B <= ~LED4_B;
                    blink <= '0;
                end else begin
                    blink <= blink + 1'b1;
                end
            end else if (state_n == DOOR) begin
                LED4_B <= 1'b0;
                // steady red until the final quarter of the door time
                if (state != DOOR || timer_n < D_LAST) begin
                    LED4_R <= 1'b1;
                    blink <= '0;
                end else begin
                    LED4_R <= blink == '0 ? ~LED4_R : LED4_R;
                    blink <= blink == TW'(DQ - 1) ? '0 : blink + 1'b1;
                end
            end else begin
                LED4_R <= 1'b0;
                LED4_B <= 1'b0;
                blink <= '0;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            LED4_R <= 1'b0;
            LED4_G <= 1'b1;
            LED4_B <= 1'b0;
        end else begin
            LED4_R <= state_n == DOOR;
            LED4_G <= state_n == IDLE;
            LED4_B <= move_n;
        end
    end
`endif
endmodule

// File: tb/tb_floor_ctrl.sv
// tb_floor_ctrl: directed scenarios plus random calls checked against a behavioural car model
module tb_floor_ctrl;
    localparam int TRAVEL = 10;
    localparam int DWELL = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [1:0] cur_floor;
    logic [3:0] req_pend;
    logic       moving, dir_up, door_open, LED4_R, LED4_G, LED4_B;

    floor_ctrl #(.FLOORS(4), .TRAVEL_CYC(TRAVEL), .DOOR_CYC(DWELL)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .cur_floor(cur_floor),
        .req_pend(req_pend),
        .moving(moving),
        .dir_up(dir_up),
        .door_open(door_open),
        .LED4_R(LED4_R),
        .LED4_G(LED4_G),
        .LED4_B(LED4_B)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // car model: mode 0 parked, 1 rising, 2 falling, 3 boarding
    int       mode, floor, elapsed;
    bit       heading_up;
    bit [3:0] calls;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit calls_beyond(input int f, input bit up);
        for (int i = 0; i < 4; i++)
            if (calls[i] && (up ? i > f : i < f)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_reset();
        mode = 0;
        floor = 0;
        elapsed = 0;
        heading_up = 1'b1;
        calls = '0;
    endtask

    task automatic m_step(input bit [3:0] r);
        bit [3:0] served;
        int step;
        served = '0;
        step = mode == 1 ? 1 : -1;
        if (mode == 0) begin
            if (calls[floor]) begin
                mode = 3;
                elapsed = 0;
                served[floor] = 1'b1;
            end else if (calls != 0) begin
                heading_up = (heading_up && calls_beyond(floor, 1'b1)) || !calls_beyond(floor, 1'b0);
                mode = heading_up ? 1 : 2;
                elapsed = 0;
            end
        end else if (mode == 3) begin
            served[floor] = 1'b1;
            if (r[floor]) elapsed = 0;
            else if (elapsed == DWELL - 1) mode = 0;
            else elapsed++;
        end else if (floor + step < 0 || floor + step > 3) begin
            mode = 0;
        end else if (elapsed == TRAVEL - 1) begin
            floor += step;
            elapsed = 0;
            if (calls[floor]) begin
                mode = 3;
                served[floor] = 1'b1;
            end else if (!calls_beyond(floor, mode == 1)) begin
                mode = 0;
            end
        end else begin
            elapsed++;
        end
        calls = (calls | r) & ~served;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".floor"}, cur_floor, floor);
        check({tag, ".pend"}, req_pend, calls);
        check({tag, ".moving"}, moving, mode == 1 || mode == 2);
        check({tag, ".dir"}, dir_up, heading_up);
        check({tag, ".door"}, door_open, mode == 3);
        check({tag, ".led"}, {LED4_R, LED4_G, LED4_B}, mode == 3 ? 3'b100 : mode == 0 ? 3'b010 : 3'b001);
    endtask

    // called at a falling edge: check, then present r for the next rising edge
    task automatic cycle(input logic [3:0] r, input string tag);
        check_all(tag);
        req = r;
        m_step(r);
        @(negedge clk);
    endtask

    task automatic idle_run(input int n, input string tag);
        repeat (n) cycle(4'b0000, tag);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        req = '0;
        m_reset();
        #1 check_all("async_rst");
        @(negedge clk);
        check_all("rst_hold");
        rst = 1'b0;
    endtask

    int   n;
    int   t_prev;
    logic [1:0] prev;
    bit   was_door;
    int   doors[$];

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // same-floor call
        cycle(4'b0001, "same");
        cycle(4'b0000, "same");
        check("same.open_2_edges", door_open, 1'b1);
        n = 0;
        repeat (10) begin
            n += int'(door_open);
            cycle(4'b0000, "same");
        end
        check("same.door_len", n, 5);
        check("same.pend_empty", req_pend, 4'b0000);

        // single trip 0 -> 3
        prev = cur_floor;
        t_prev = -1;
        for (int k = 0; k < 45; k++) begin
            if (cur_floor != prev) begin
                if (t_prev >= 0) check("trip.step_gap", k - t_prev, TRAVEL);
                t_prev = k;
                prev = cur_floor;
            end
            cycle(k == 0 ? 4'b1000 : 4'b0000, "trip");
        end
        check("trip.floor", cur_floor, 2'd3);
        check("trip.dir", dir_up, 1'b1);
        check("trip.parked", {moving, door_open}, 2'b00);

        // door held open by a call at the current floor
        for (int k = 0; k < 20; k++) begin
            if (k >= 3) begin
                check("hold.door", door_open, 1'b1);
                check("hold.pend3", req_pend[3], 1'b0);
            end
            cycle(4'b1000, "hold");
        end
        n = 0;
        repeat (10) begin
            n += int'(door_open);
            cycle(4'b0000, "hold");
        end
        check("hold.release_len", n, 5);

        // reset in the middle of a move
        pulse_reset();
        cycle(4'b1000, "mid");
        idle_run(24, "mid");
        check("mid.at2", cur_floor, 2'd2);
        check("mid.moving", moving, 1'b1);
        pulse_reset();
        check("mid.floor0", cur_floor, 2'd0);
        check("mid.pend0", req_pend, 4'b0000);
        check("mid.led_g", {LED4_R, LED4_G, LED4_B}, 3'b010);
        check("mid.dir1", dir_up, 1'b1);

        // direction priority from floor 1 heading up
        cycle(4'b0010, "p1");
        idle_run(20, "p1");
        check("prio.start_floor", cur_floor, 2'd1);
        check("prio.start_dir", dir_up, 1'b1);
        doors.delete();
        was_door = 1'b0;
        for (int k = 0; k < 90; k++) begin
            if (door_open && !was_door) doors.push_back(int'(cur_floor));
            was_door = door_open;
            if (doors.size() == 1 && moving) check("prio.leg2_dir", dir_up, 1'b0);
            cycle(k == 0 ? 4'b1001 : 4'b0000, "prio");
        end
        check("prio.stops", doors.size(), 2);
        check("prio.first", doors.size() > 0 ? doors[0] : -1, 3);
        check("prio.second", doors.size() > 1 ? doors[1] : -1, 0);

        // intermediate stop at 2 on the way to 3
        doors.delete();
        was_door = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (door_open && !was_door) doors.push_back(int'(cur_floor));
            was_door = door_open;
            cycle(k == 0 ? 4'b1000 : k == 15 ? 4'b0100 : 4'b0000, "stop");
        end
        check("stop.stops", doors.size(), 2);
        check("stop.first", doors.size() > 0 ? doors[0] : -1, 2);
        check("stop.second", doors.size() > 1 ? doors[1] : -1, 3);

        // random sparse calls with the occasional reset
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 599) == 0) pulse_reset();
            cycle($urandom_range(0, 6) == 0 ? 4'($urandom) : 4'b0000, "rand");
        end
        check_all("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/floor_ctrl.md
FLOOR_CTRL -- requirements
Module: floor_ctrl

Interface
REQ-001 SHALL have parameter FLOORS, default 4: number of served floors, range 2..16.
REQ-002 SHALL have parameter TRAVEL_CYC, default 50000000: clock cycles to travel one floor, minimum 2.
REQ-003 SHALL have parameter DOOR_CYC, default 100000000: clock cycles the door stays open, minimum 2.
REQ-004 SHALL have local parameter FW = $clog2(FLOORS): floor-index width.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port req, input, FLOORS bits: one bit per floor call; level, sampled every cycle.
REQ-008 SHALL have port cur_floor, output, FW bits: current car floor, 0 = ground.
REQ-009 SHALL have port req_pend, output, FLOORS bits: latched, unserved requests.
REQ-010 SHALL have port moving, output, 1 bit: car is in MOVE_UP or MOVE_DOWN.
REQ-011 SHALL have port dir_up, output, 1 bit: last or current travel direction, 1 = up.
REQ-012 SHALL have port door_open, output, 1 bit: state is DOOR.
REQ-013 SHALL have ports LED4_R, LED4_G, LED4_B, outputs, 1 bit each: registered status RGB LED.

Function
REQ-014 SHALL update req_pend at each edge as (req_pend | req) & ~clr, where clr is the arrival or door-open clear of the current floor; on the same bit in the same cycle, clear wins.
REQ-015 SHALL implement FSM states IDLE, MOVE_UP, MOVE_DOWN and DOOR.
REQ-016 SHALL, in IDLE with req_pend[cur_floor]=1, enter DOOR on the next edge and clear that bit.
REQ-017 SHALL, in IDLE with requests pending only elsewhere: go to MOVE_UP if dir_up=1 and any request is above; else to MOVE_DOWN if any request is below; else to MOVE_UP.
REQ-018 SHALL, on entering any MOVE or DOOR state, clear a cycle timer to 0.
REQ-019 SHALL, in MOVE_UP/MOVE_DOWN, increment/decrement cur_floor by exactly 1 after TRAVEL_CYC cycles in that state.
REQ-020 SHALL, on the edge cur_floor changes: enter DOOR and clear the new floor's bit if it is pending; else stay moving, with timer reset, if more requests lie in the same direction; else enter IDLE.
REQ-021 SHALL never drive cur_floor below 0 or above FLOORS-1; MOVE_UP at FLOORS-1 or MOVE_DOWN at 0 is illegal and SHALL fall to IDLE without changing cur_floor.
REQ-022 SHALL set dir_up=1 on entering MOVE_UP and dir_up=0 on entering MOVE_DOWN; dir_up SHALL hold otherwise.
REQ-023 SHALL remain in DOOR for exactly DOOR_CYC cycles, then enter IDLE.
REQ-024 SHALL, during DOOR, restart the door timer at 0 and keep the bit clear when req[cur_floor]=1.
REQ-025 SHALL drive the LED from the next state, registered: IDLE = G, MOVE = B, DOOR = R, one colour at a time.
REQ-026 SHALL ignore req bits at or above FLOORS; the timer SHALL be wide enough for max(TRAVEL_CYC, DOOR_CYC) without wrap.

Reset
REQ-027 SHALL, while rst=1, force state=IDLE, cur_floor=0, req_pend=0, timer=0, dir_up=1, moving=0, door_open=0, and LED R/G/B = 0/1/0.
REQ-028 SHALL abort any in-progress move or door cycle on reset mid-operation, with no partial floor update; operation resumes from IDLE on the first edge after rst deasserts.

Configuration
REQ-029 SHALL, with macro FLOOR_CTRL_BLINK_EN defined, toggle LED4_B every TRAVEL_CYC/4 cycles while moving, starting on, and toggle LED4_R every DOOR_CYC/4 cycles during the final quarter of DOOR.
REQ-030 SHALL, without FLOOR_CTRL_BLINK_EN, hold the LEDs steady as in REQ-025, with no blink logic in the netlist.

Verification (FLOORS=4, TRAVEL_CYC=10, DOOR_CYC=5)
REQ-031 SHALL cover reset: rst pulse mid-move at cur_floor=2 -> cur_floor=0, req_pend=0, LED G only, dir_up=1.
REQ-032 SHALL cover the same-floor call: IDLE at 0, req=0001 for 1 cycle -> door_open=1 two edges later for exactly 5 cycles, then IDLE, req_pend=0.
REQ-033 SHALL cover a single trip: IDLE at 0, req=1000 -> MOVE_UP, cur_floor steps 1, 2, 3 every 10 cycles, then DOOR at 3, then IDLE with dir_up=1.
REQ-034 SHALL cover direction priority: at floor 1 with dir_up=1, req=1001 together -> serve floor 3 first, then floor 0, with dir_up=0 during the second leg.
REQ-035 SHALL cover the intermediate stop: moving up 0->3 and req[2] asserted before reaching 2 -> door opens at 2, then continues to 3.
REQ-036 SHALL cover clear-wins and door extend: req[cur_floor] held through DOOR -> door stays open while held, req_pend bit never set, DOOR exits 5 cycles after release.
